dht11_receptor: RTL and testbench
=================================

Name: dht11_receptor

Overview:
- Datapath-side receiver for the DHT11 single-wire interface; sits directly under the DHT11 interface control unit.
- After the control unit releases the start pulse, it times the sensor response and the 40 data-bit pulses, and shifts in the frame.
- It checks the checksum and hands humidity/temperature bytes plus status (done, ok, timeout) back to the control unit.

Parameters:
CICLOS_US, 50, clock cycles per microsecond (50 MHz board clock)
LIMIAR_BIT_US, 40, high-phase width in us at or above which a bit decodes as 1
RESP_MIN_US, 40, minimum width in us of each 80 us response phase
TIMEOUT_US, 200, maximum width in us of any single line level while receiving

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-low reset
iniciar  input  1  one-cycle pulse: start waiting for sensor response
dht_in  input  1  raw sensor data line (asynchronous)
pronto  output  1  one-cycle pulse: frame finished, whether ok or failed
medida_ok  output  1  last frame received completely with correct checksum
erro_timeout  output  1  last attempt aborted by timeout or short response phase
umidade  output  8  humidity integer byte (frame byte 4)
temperatura  output  8  temperature integer byte (frame byte 2)
dados  output  40  full raw frame, MSB first as received
db_estado  output  4  current state code, for debug

Behaviour:
- All flops update on posedge clock. Reset is sampled only at posedge: reset=0 forces state OCIOSO and clears all outputs, counters and shift register to 0. A synchronizer reset value of 1 avoids a false edge.
- Input path: dht_in passes through a 2-flop synchronizer (s1, s2) and a history flop s_ant. Falling edge = s_ant & ~s2; rising edge = ~s_ant & s2.
- Time base:
  - Prescaler counts 0..CICLOS_US-1 and pulses tick_us on wrap.
  - 8-bit us counter increments on tick_us and saturates at 255.
  - Prescaler and us counter both clear on every edge and on every state change.
- States (db_estado code): OCIOSO 0, ESPERA_RESP 1, RESP_BAIXO 2, RESP_ALTO 3, BIT_BAIXO 4, BIT_ALTO 5, VERIFICA 6, FIM 7, ERRO 8.
- Transitions:
  - OCIOSO: iniciar -> ESPERA_RESP. Clear dados, bit counter, medida_ok and erro_timeout.
  - ESPERA_RESP: falling edge -> RESP_BAIXO.
  - RESP_BAIXO: rising edge -> RESP_ALTO if us >= RESP_MIN_US, else ERRO.
  - RESP_ALTO: falling edge -> BIT_BAIXO if us >= RESP_MIN_US, else ERRO.
  - BIT_BAIXO: rising edge -> BIT_ALTO.
  - BIT_ALTO: falling edge shifts in the bit (us >= LIMIAR_BIT_US -> 1, else 0) into dados LSB, shifting left, and increments the 6-bit bit counter. If the counter reaches 40 -> VERIFICA, else -> BIT_BAIXO.
  - VERIFICA -> FIM unconditionally. Latch medida_ok = (dados[39:32] + dados[31:24] + dados[23:16] + dados[15:8]) mod 256 == dados[7:0]. Latch umidade = dados[39:32] and temperatura = dados[23:16] only when ok; otherwise keep the previous values.
  - FIM: pronto=1 for exactly one cycle -> OCIOSO.
  - ERRO: set erro_timeout=1, medida_ok=0, pronto=1 for one cycle -> OCIOSO.
- Timeout: in any state 1..5, us counter reaching TIMEOUT_US -> ERRO. Timeout has priority over a same-cycle edge.
- Latency: pronto asserts 2 cycles after the cycle in which the 40th falling edge is detected (VERIFICA, then FIM). Pin-to-detect adds 2 synchronizer cycles.
- Hold rules:
  - medida_ok and erro_timeout hold until the next accepted iniciar.
  - dados holds the partial frame after ERRO.
- iniciar is ignored in every state except OCIOSO; there is no restart mid-frame.
- reset=0 mid-frame aborts immediately to OCIOSO with no pronto pulse.
- Bit counter never exceeds 40. Extra edges after FIM are ignored in OCIOSO.

Test Plan:
- Test parameters: CICLOS_US=2.
- Valid frame: iniciar, 80 us low / 80 us high response, then bytes 0x23 0x00 0x19 0x00 0x3C (50 us low; 27 us high = 0, 70 us high = 1) -> one pronto pulse; medida_ok=1, umidade=35, temperatura=25, dados=0x230019003C, erro_timeout=0.
- Bad checksum: same frame, last byte 0x3D -> pronto pulse; medida_ok=0; umidade/temperatura keep previous values (35/25).
- Timeout: iniciar with dht_in held high -> ERRO after 200 us (400 cycles + sync); pronto=1, erro_timeout=1, medida_ok=0. Repeat with the line stuck low mid-bit (bit 17) -> same result.
- Threshold boundary: all bits with a 39 us high phase -> dados=0. All bits with a 40 us high phase -> dados=0xFFFFFFFFFF, checksum fails, so medida_ok=0.
- Short response: response low phase of 30 us -> ERRO, erro_timeout=1, pronto pulse.
- Control: a second iniciar during bit 10 is ignored and the frame completes normally. reset=0 for one cycle during bit 20 -> state 0, no pronto, all outputs 0; a following iniciar plus a valid frame then succeeds.

Source files
------------

// File: rtl/dht11_receptor.sv
// rtl/dht11_receptor.sv - DHT11 single-wire frame receiver: response/bit timing, shift-in, checksum
module dht11_receptor #(
  parameter int CICLOS_US     = 50,
  parameter int LIMIAR_BIT_US = 40,
  parameter int RESP_MIN_US   = 40,
  parameter int TIMEOUT_US    = 200
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        iniciar,
  input  logic        dht_in,
  output logic        pronto,
  output logic        medida_ok,
  output logic        erro_timeout,
  output logic [7:0]  umidade,
  output logic [7:0]  temperatura,
  output logic [39:0] dados,
  output logic [3:0]  db_estado
);
  localparam int            PW        = (CICLOS_US > 1) ? $clog2(CICLOS_US) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CICLOS_US - 1);
  localparam logic [7:0]    LIMIAR    = 8'(LIMIAR_BIT_US);
  localparam logic [7:0]    RESP_MIN  = 8'(RESP_MIN_US);
  localparam logic [7:0]    TIMEOUT   = 8'(TIMEOUT_US);

  typedef enum logic [3:0] {
    OCIOSO      = 4'd0,
    ESPERA_RESP = 4'd1,
    RESP_BAIXO  = 4'd2,
    RESP_ALTO   = 4'd3,
    BIT_BAIXO   = 4'd4,
    BIT_ALTO    = 4'd5,
    VERIFICA    = 4'd6,
    FIM         = 4'd7,
    ERRO        = 4'd8
  } estado_t;

  estado_t       estado, prox;
  logic          s1, s2, s_ant;
  logic          borda_desc, borda_sub;
  logic [PW-1:0] presc;
  logic          tick_us;
  logic [7:0]    us, us_agora;
  logic [5:0]    n_bits;
  logic [7:0]    soma;
  logic          ocupado, zera_tempo;
  logic          limpar, deslocar, verificar, falhar;

  always_ff @(posedge clock) begin
    if (!reset) begin
      s1    <= 1'b1;
      s2    <= 1'b1;
      s_ant <= 1'b1;
    end else begin
      s1    <= dht_in;
      s2    <= s1;
      s_ant <= s2;
    end
  end

  assign borda_desc = s_ant & ~s2;
  assign borda_sub  = ~s_ant & s2;
  assign tick_us    = (presc == PRESC_MAX);
  // Count includes the current cycle so a level is measured edge to edge.
  assign us_agora   = (tick_us && us != 8'hFF) ? us + 8'd1 : us;
  assign soma       = dados[39:32] + dados[31:24] + dados[23:16] + dados[15:8];
  assign ocupado    = estado inside {ESPERA_RESP, RESP_BAIXO, RESP_ALTO, BIT_BAIXO, BIT_ALTO};
  assign zera_tempo = borda_desc | borda_sub | (prox != estado);
  assign db_estado  = estado;

  always_ff @(posedge clock) begin
    if (!reset) begin
      estado <= OCIOSO;
      presc  <= '0;
      us     <= '0;
    end else begin
      estado <= prox;
      if (zera_tempo) begin
        presc <= '0;
        us    <= '0;
      end else begin
        presc <= tick_us ? '0 : presc + 1'b1;
        us    <= us_agora;
      end
    end
  end

  always_comb begin
    prox      = estado;
    limpar    = 1'b0;
    deslocar  = 1'b0;
    verificar = 1'b0;
    pronto    = 1'b0;
    case (estado)
      OCIOSO: if (iniciar) begin
        prox   = ESPERA_RESP;
        limpar = 1'b1;
      end
      ESPERA_RESP: if (borda_desc) prox = RESP_BAIXO;
      RESP_BAIXO:  if (borda_sub)  prox = (us_agora >= RESP_MIN) ? RESP_ALTO : ERRO;
      RESP_ALTO:   if (borda_desc) prox = (us_agora >= RESP_MIN) ? BIT_BAIXO : ERRO;
      BIT_BAIXO:   if (borda_sub)  prox = BIT_ALTO;
      BIT_ALTO: if (borda_desc) begin
        deslocar = 1'b1;
        prox     = (n_bits == 6'd39) ? VERIFICA : BIT_BAIXO;
      end
      VERIFICA: begin
        verificar = 1'b1;
        prox      = FIM;
      end
      FIM: begin
        pronto = 1'b1;
        prox   = OCIOSO;
      end
      ERRO: begin
        pronto = 1'b1;
        prox   = OCIOSO;
      end
      default: prox = OCIOSO;
    endcase
    if (ocupado && us_agora >= TIMEOUT) begin
      prox     = ERRO;
      deslocar = 1'b0;
    end
    falhar = (prox == ERRO) && (estado != ERRO);
  end

  // Status is registered on entry to ERRO/FIM so it is valid alongside pronto.
  always_ff @(posedge clock) begin
    if (!reset) begin
      dados        <= '0;
      n_bits       <= '0;
      medida_ok    <= 1'b0;
      erro_timeout <= 1'b0;
      umidade      <= '0;
      temperatura  <= '0;
    end else begin
      if (limpar) begin
        dados        <= '0;
        n_bits       <= '0;
        medida_ok    <= 1'b0;
        erro_timeout <= 1'b0;
      end
      if (deslocar) begin
        dados  <= {dados[38:0], us_agora >= LIMIAR};
        n_bits <= n_bits + 6'd1;
      end
      if (verificar) begin
        medida_ok <= (soma == dados[7:0]);
        if (soma == dados[7:0]) begin
          umidade     <= dados[39:32];
          temperatura <= dados[23:16];
        end
      end
      if (falhar) begin
        erro_timeout <= 1'b1;
        medida_ok    <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_dht11_receptor.sv
// tb/tb_dht11_receptor.sv - randomized scoreboard bench for dht11_receptor
module tb_dht11_receptor;
  localparam int CYC        = 2;
  localparam int LIMIAR_US  = 40;
  localparam int RESP_MIN   = 40;
  localparam int TIMEOUT_US = 200;

  typedef struct {
    logic        ok;
    logic        err;
    logic [39:0] d;
    logic [7:0]  u;
    logic [7:0]  t;
  } exp_t;

  logic        clock, reset, iniciar, dht_in;
  logic        pronto, medida_ok, erro_timeout;
  logic [7:0]  umidade, temperatura;
  logic [39:0] dados;
  logic [3:0]  db_estado;

  int   n_vec = 0;
  int   n_fail = 0;
  int   w[$];
  exp_t exp_q[$];
  exp_t mon_e;
  logic pronto_prev = 1'b0;
  logic [7:0] m_u = '0;
  logic [7:0] m_t = '0;

  dht11_receptor #(.CICLOS_US(CYC)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .dht_in(dht_in),
    .pronto(pronto), .medida_ok(medida_ok), .erro_timeout(erro_timeout),
    .umidade(umidade), .temperatura(temperatura), .dados(dados), .db_estado(db_estado)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Line widths in us: index 0 high wait, 1/2 response, then low/high per bit.
  task automatic build(input logic [39:0] data, input int rl, input int rh, input int nbits,
                       input int lo, input int hi0, input int hi1);
    w.delete();
    w.push_back(20);
    w.push_back(rl);
    w.push_back(rh);
    for (int i = 0; i < nbits; i++) begin
      w.push_back(lo < 0 ? int'($urandom_range(60, 40)) : lo);
      if (data[39-i]) w.push_back(hi1 < 0 ? int'($urandom_range(75, 40)) : hi1);
      else            w.push_back(hi0 < 0 ? int'($urandom_range(39, 15)) : hi0);
    end
    w.push_back(nbits == 40 ? 50 : 250);
  endtask

  task automatic model(output exp_t e);
    logic [39:0] d;
    logic        err;
    int          nb;
    int          s;
    d = '0; err = 1'b0; nb = 0;
    for (int p = 0; p < w.size(); p++) begin
      if (w[p] >= TIMEOUT_US) begin err = 1'b1; break; end
      if ((p == 1 || p == 2) && w[p] < RESP_MIN) begin err = 1'b1; break; end
      if (p >= 4 && p % 2 == 0) begin
        d = {d[38:0], w[p] >= LIMIAR_US};
        nb++;
        if (nb == 40) break;
      end
    end
    if (nb < 40) err = 1'b1;
    e.err = err;
    e.d   = d;
    e.ok  = 1'b0;
    if (!err) begin
      s = int'(d[39:32]) + int'(d[31:24]) + int'(d[23:16]) + int'(d[15:8]);
      e.ok = ((s % 256) == int'(d[7:0]));
      if (e.ok) begin
        m_u = d[39:32];
        m_t = d[23:16];
      end
    end
    e.u = m_u;
    e.t = m_t;
  endtask

  task automatic drive(input int ini_phase, input int rst_phase);
    for (int p = 0; p < w.size(); p++) begin
      dht_in = (p % 2 == 0);
      if (p == rst_phase) begin
        reset = 1'b0;
        @(negedge clock);
        reset  = 1'b1;
        dht_in = 1'b1;
        return;
      end
      if (p == ini_phase) begin
        iniciar = 1'b1;
        @(negedge clock);
        iniciar = 1'b0;
        repeat (w[p] * CYC - 1) @(negedge clock);
      end else begin
        repeat (w[p] * CYC) @(negedge clock);
      end
    end
    dht_in = 1'b1;
  endtask

  task automatic run(input int ini_phase, input int rst_phase);
    exp_t e;
    int   n;
    if (rst_phase < 0) begin
      model(e);
      exp_q.push_back(e);
    end
    iniciar = 1'b1;
    @(negedge clock);
    iniciar = 1'b0;
    drive(ini_phase, rst_phase);
    if (rst_phase < 0) begin
      n = 0;
      while (exp_q.size() != 0 && n < 2000) begin
        @(negedge clock);
        n++;
      end
      chk("pronto_arrived", 40'(exp_q.size()), 40'd0);
    end
    repeat (20) @(negedge clock);
  endtask

  always @(negedge clock) begin
    if (pronto) begin
      chk("pronto_one_cycle", {39'd0, pronto_prev}, 40'd0);
      if (exp_q.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL unexpected_pronto: got pronto=1, required no pending frame");
      end else begin
        mon_e = exp_q.pop_front();
        chk("medida_ok",    {39'd0, medida_ok},    {39'd0, mon_e.ok});
        chk("erro_timeout", {39'd0, erro_timeout}, {39'd0, mon_e.err});
        chk("dados",        dados,                 mon_e.d);
        chk("umidade",      {32'd0, umidade},      {32'd0, mon_e.u});
        chk("temperatura",  {32'd0, temperatura},  {32'd0, mon_e.t});
      end
    end
    pronto_prev = pronto;
  end

  initial begin
    logic [7:0]  b4, b3, b2, b1, ck;
    logic [39:0] all1;
    reset = 1'b0; iniciar = 1'b0; dht_in = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("reset_estado", {36'd0, db_estado}, 40'd0);
    chk("reset_dados", dados, 40'd0);
    chk("reset_flags", {38'd0, medida_ok, erro_timeout}, 40'd0);
    chk("reset_pronto", {39'd0, pronto}, 40'd0);

    build(40'h230019003C, 80, 80, 40, 50, 27, 70);   run(-1, -1);
    build(40'h230019003D, 80, 80, 40, 50, 27, 70);   run(-1, -1);
    w.delete(); w.push_back(250);                    run(-1, -1);
    build(40'h230019003C, 80, 80, 17, 50, 27, 70);   run(-1, -1);
    all1 = '1;
    build(all1, 80, 80, 40, 50, 39, 39);             run(-1, -1);
    build(all1, 80, 80, 40, 50, 40, 40);             run(-1, -1);
    build(40'h230019003C, 30, 80, 0, 50, 27, 70);    run(-1, -1);
    build(40'h230019003C, 80, 80, 40, 50, 27, 70);   run(3 + 2 * 10, -1);

    build(40'h230019003C, 80, 80, 40, 50, 27, 70);   run(-1, 3 + 2 * 20);
    m_u = '0; m_t = '0;
    chk("midreset_estado", {36'd0, db_estado}, 40'd0);
    chk("midreset_dados", dados, 40'd0);
    chk("midreset_flags", {38'd0, medida_ok, erro_timeout}, 40'd0);
    chk("midreset_bytes", {24'd0, umidade, temperatura}, 40'd0);
    chk("midreset_pronto", {39'd0, pronto}, 40'd0);
    build(40'h230019003C, 80, 80, 40, 50, 27, 70);   run(-1, -1);

    for (int k = 0; k < 3; k++) begin
      b4 = 8'($urandom); b3 = 8'($urandom); b2 = 8'($urandom); b1 = 8'($urandom);
      ck = b4 + b3 + b2 + b1;
      if ($urandom_range(1, 0) == 1) ck = ck ^ 8'(1 + $urandom_range(254, 0));
      build({b4, b3, b2, b1, ck}, int'($urandom_range(100, 40)), int'($urandom_range(100, 40)),
            40, -1, -1, -1);
      run(-1, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
